// File: rtl/or1200_reg128_pack.sv
// Word assembler: gathers BEATS input beats into one OUT_W word and strobes
// it out for a single cycle; supports flush of a partial word and lock back-pressure.
module or1200_reg128_pack #(
  parameter int BEAT_W    = 32,
  parameter int BEATS     = 4,
  parameter int MSB_FIRST = 1,
  localparam int OUT_W    = BEAT_W * BEATS,
  localparam int CNT_W    = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              lock,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [BEAT_W-1:0] in_data,
  output logic              out_ce,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  beat_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, COMMIT = 2'd2} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [OUT_W-1:0]   asm_buf, asm_nx, data_nx, merged;
  logic               ce_nx, accept, last_beat;

  // Bit offset of assembly slot idx; slot 0 sits at the top when MSB_FIRST.
  function automatic int slot_base(input logic [CNT_W-1:0] idx);
    if (MSB_FIRST != 0) return (BEATS - 1 - int'(idx)) * BEAT_W;
    return int'(idx) * BEAT_W;
  endfunction

  assign in_rdy    = !lock && !flush && (state != COMMIT);
  assign accept    = in_vld && in_rdy;
  assign last_beat = (cnt == CNT_W'(BEATS - 1));
  assign busy      = (state != IDLE);
  assign beat_cnt  = cnt;

  always_comb begin
    merged = asm_buf;
    merged[slot_base(cnt) +: BEAT_W] = in_data;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    asm_nx   = asm_buf;
    data_nx  = out_data;
    ce_nx    = 1'b0;
    case (state)
      COMMIT: state_nx = IDLE;
      default: begin
        if (flush) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          asm_nx   = '0;
        end else if (accept) begin
          if (last_beat) begin
            state_nx = COMMIT;
            cnt_nx   = '0;
            asm_nx   = '0;
            data_nx  = merged;
            ce_nx    = 1'b1;
          end else begin
            state_nx = FILL;
            cnt_nx   = cnt + CNT_W'(1);
            asm_nx   = merged;
          end
        end
      end
    endcase
  end

  // Register stage: control, assembly buffer and committed word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      asm_buf  <= '0;
      out_data <= '0;
      out_ce   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      asm_buf  <= asm_nx;
      out_data <= data_nx;
      out_ce   <= ce_nx;
    end
  end

endmodule

// File: tb/tb_or1200_reg128_pack.sv
// Bench for or1200_reg128_pack: two instances (MSB-first and LSB-first) driven
// in parallel, checked every cycle against a queue-based word model.
module tb_or1200_reg128_pack;

  logic          clk = 1'b0;
  logic          rst, flush, lock, in_vld;
  logic [31:0]   in_data;
  logic          rdy_a, ce_a, busy_a, rdy_b, ce_b, busy_b;
  logic [127:0]  data_a, data_b;
  logic [1:0]    cnt_a, cnt_b;

  always #5 clk = ~clk;

  or1200_reg128_pack #(.BEAT_W(32), .BEATS(4), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .lock(lock), .in_vld(in_vld),
    .in_rdy(rdy_a), .in_data(in_data), .out_ce(ce_a), .out_data(data_a),
    .busy(busy_a), .beat_cnt(cnt_a));

  or1200_reg128_pack #(.BEAT_W(32), .BEATS(4), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .lock(lock), .in_vld(in_vld),
    .in_rdy(rdy_b), .in_data(in_data), .out_ce(ce_b), .out_data(data_b),
    .busy(busy_b), .beat_cnt(cnt_b));

  int           checks = 0;
  int           errors = 0;
  bit           chk_en = 0;
  logic [31:0]  q[$];
  bit           m_commit;
  logic [127:0] m_word_a, m_word_b;
  logic         e_rdy, e_busy;
  int           ce_cyc[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_commit = 0;
    m_word_a = '0;
    m_word_b = '0;
  endtask

  // Word-level model: beats queue up; the fourth completes a word shown next cycle.
  task automatic model_step();
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_commit) m_commit = 0;
    else if (flush) q.delete();
    else if (in_vld && !lock) begin
      q.push_back(in_data);
      if (q.size() == 4) begin
        m_word_a = {q[0], q[1], q[2], q[3]};
        m_word_b = {q[3], q[2], q[1], q[0]};
        m_commit = 1;
        q.delete();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    in_vld  = v;
    in_data = d;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      e_rdy  = !lock && !flush && !m_commit;
      e_busy = (q.size() != 0) || m_commit;
      chk("rdy_a",  128'(rdy_a),  128'(e_rdy));
      chk("rdy_b",  128'(rdy_b),  128'(e_rdy));
      chk("ce_a",   128'(ce_a),   128'(m_commit));
      chk("ce_b",   128'(ce_b),   128'(m_commit));
      chk("busy_a", 128'(busy_a), 128'(e_busy));
      chk("busy_b", 128'(busy_b), 128'(e_busy));
      chk("cnt_a",  128'(cnt_a),  128'(q.size()));
      chk("cnt_b",  128'(cnt_b),  128'(q.size()));
      chk("data_a", data_a, m_word_a);
      chk("data_b", data_b, m_word_b);
    end
  end

  logic [31:0] t1 [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

  initial begin
    rst = 1'b0; flush = 1'b0; lock = 1'b0; in_vld = 1'b0; in_data = '0;
    model_reset();
    #1;
    chk("rst_ce",   128'(ce_a),   128'(0));
    chk("rst_busy", 128'(busy_a), 128'(0));
    chk("rst_cnt",  128'(cnt_a),  128'(0));
    chk("rst_data", data_a, 128'h0);
    chk_en = 1;
    tick(); tick();
    rst = 1'b1;

    // Back-to-back word, both slot orders
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, t1[i]);
      #1 chk("t1_rdy", 128'(rdy_a), 128'(1));
      tick();
    end
    drive(1'b0, 32'h0);
    chk("t1_ce",     128'(ce_a),  128'(1));
    chk("t1_rdy_c",  128'(rdy_a), 128'(0));
    chk("t1_busy_c", 128'(busy_a), 128'(1));
    chk("t1_data_a", data_a, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("t1_data_b", data_b, 128'hCCDDEEFF_8899AABB_44556677_00112233);
    tick();
    chk("t1_ce_off", 128'(ce_a),  128'(0));
    chk("t1_idle",   128'(busy_a), 128'(0));

    // Flush of a partial word
    drive(1'b1, 32'hAAAA0000); tick();
    drive(1'b1, 32'hAAAA0001); tick();
    chk("fl_cnt2", 128'(cnt_a), 128'(2));
    flush = 1'b1; drive(1'b1, 32'hBAD0BAD0); tick();
    flush = 1'b0;
    chk("fl_cnt0", 128'(cnt_a), 128'(0));
    chk("fl_ce",   128'(ce_a),  128'(0));
    for (int i = 1; i <= 4; i++) begin drive(1'b1, 32'(i)); tick(); end
    drive(1'b0, 32'h0);
    chk("fl_ce_w",   128'(ce_a), 128'(1));
    chk("fl_data_a", data_a, 128'h00000001_00000002_00000003_00000004);
    tick();

    // Lock holds a partial word
    for (int i = 1; i <= 3; i++) begin drive(1'b1, 32'(i * 32'h11)); tick(); end
    lock = 1'b1; drive(1'b1, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      #1 chk("lk_rdy", 128'(rdy_a), 128'(0));
      tick();
      chk("lk_cnt", 128'(cnt_a), 128'(3));
      chk("lk_ce",  128'(ce_a),  128'(0));
    end
    lock = 1'b0; tick();
    drive(1'b0, 32'h0);
    chk("lk_ce_w",   128'(ce_a), 128'(1));
    chk("lk_data_a", data_a, 128'h00000011_00000022_00000033_DEADBEEF);
    tick();

    // Continuous valid: two words, pulses five cycles apart
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'(k)); tick();
      if (ce_a) ce_cyc.push_back(k);
    end
    drive(1'b0, 32'h0);
    chk("ct_words", 128'(ce_cyc.size()), 128'(2));
    if (ce_cyc.size() == 2) chk("ct_gap", 128'(ce_cyc[1] - ce_cyc[0]), 128'(5));
    chk("ct_data_a", data_a, 128'h00000005_00000006_00000007_00000008);
    tick();

    // Asynchronous reset mid-fill
    drive(1'b1, 32'h77770000); tick();
    drive(1'b1, 32'h77770001); tick();
    drive(1'b0, 32'h0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("ar_cnt",  128'(cnt_a),  128'(0));
    chk("ar_busy", 128'(busy_a), 128'(0));
    chk("ar_ce",   128'(ce_a),   128'(0));
    chk("ar_data", data_a, 128'h0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin drive(1'b1, 32'hA0 + 32'(i)); tick(); end
    drive(1'b0, 32'h0);
    chk("ar_ce_w",   128'(ce_a), 128'(1));
    chk("ar_data_a", data_a, 128'h000000A0_000000A1_000000A2_000000A3);
    tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      in_vld  = ($urandom % 4) != 0;
      lock    = ($urandom % 6) == 0;
      flush   = ($urandom % 12) == 0;
      in_data = $urandom;
      if (($urandom % 150) == 0) begin
        rst = 1'b0;
        model_reset();
      end else rst = 1'b1;
      tick();
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/or1200_reg128_pack.md
Name: or1200_reg128_pack

Overview:
- Upstream word assembler for the 128-bit enable register.
- Collects four 32-bit beats, e.g. key or plaintext words written over the 32-bit datapath, into one 128-bit word.
- When the word is complete, presents it on out_data with a single-cycle out_ce strobe that drives the downstream register's ce/in pair directly.
- Provides flush (abort partial word) and lock (back-pressure while the consuming engine is busy).

Parameters:
BEAT_W, 32, width of one input beat in bits.
BEATS, 4, beats per output word; power of two, at least 2.
MSB_FIRST, 1, 1 = first accepted beat lands in out_data[OUT_W-1 -: BEAT_W]; 0 = first beat lands in out_data[BEAT_W-1:0].
(Derived, not overridable: OUT_W = BEAT_W*BEATS = 128; CNT_W = log2(BEATS) = 2.)

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset.
flush  input  1  synchronous abort of the partial word.
lock  input  1  1 = stop accepting beats.
in_vld  input  1  in_data is valid this cycle.
in_rdy  output  1  block can accept a beat this cycle.
in_data  input  BEAT_W  input beat.
out_ce  output  1  one-cycle strobe; out_data is a complete new word.
out_data  output  OUT_W  assembled word; holds its last committed value.
busy  output  1  partial word held, or commit in progress.
beat_cnt  output  CNT_W  number of beats held in the current partial word.

Behaviour:
- Reset:
  - Interface decision: one clock; reset is asynchronous and active-low, port rst (clock port clk).
  - rst low asynchronously clears state to IDLE, beat_cnt=0, out_ce=0, out_data=0, busy=0 and the internal assembly buffer to 0.
  - Reset asserted mid-fill discards the partial word and produces no out_ce.
- States:
  - IDLE: beat_cnt=0.
  - FILL: beat_cnt in 1..BEATS-1.
  - COMMIT: exactly one cycle.
- in_rdy (combinational) = !lock && !flush && (state != COMMIT).
- Accept occurs when in_vld && in_rdy. Each accept:
  - writes in_data into assembly slot beat_cnt; slot 0 = MSBs when MSB_FIRST=1, LSBs otherwise;
  - increments beat_cnt.
- Transitions:
  - IDLE -> FILL on accept.
  - FILL -> FILL on accept while beat_cnt < BEATS-1.
  - FILL -> COMMIT on the accept that fills slot BEATS-1. At that edge:
    - out_data <= complete word, including the beat accepted that cycle;
    - out_ce <= 1;
    - beat_cnt <= 0;
    - the assembly buffer is cleared.
  - COMMIT -> IDLE unconditionally; out_ce <= 0.
- Latency: out_ce is high in the cycle immediately after the final beat is accepted. Minimum word period is BEATS+1 cycles, because the COMMIT cycle deasserts in_rdy.
- out_ce is registered and high for exactly one cycle per word; never two consecutive cycles.
- out_data changes only on entry to COMMIT (or at reset). It is stable outside that edge, so the downstream register may also sample it late.
- flush:
  - In IDLE/FILL: next state IDLE, beat_cnt=0, buffer cleared, out_data unchanged, no out_ce.
  - A beat presented in the same cycle is not accepted, since in_rdy=0.
  - In COMMIT: the strobe already in flight completes; the state returns to IDLE as normal.
- lock:
  - Only gates acceptance; the partial word is retained.
  - lock in the COMMIT cycle has no effect on the strobe.
- in_vld without in_rdy: beat is ignored; the upstream source must hold it.
- busy = (state != IDLE).
- beat_cnt wraps BEATS-1 -> 0 only through COMMIT; no other wrap path.

Test Plan:
- Reset, then 4 back-to-back beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with in_vld=1 -> in_rdy=1 on each; out_ce high exactly one cycle after the 4th beat; out_data = 0x00112233_44556677_8899AABB_CCDDEEFF; in_rdy=0 during that cycle; busy 1 during fill and COMMIT, 0 after.
- MSB_FIRST=0 with the same beats -> out_data = 0xCCDDEEFF_8899AABB_44556677_00112233.
- 2 beats, flush for 1 cycle, then 4 beats 0x1..0x4 -> no out_ce after the flush; one out_ce after the 4th new beat; out_data = 0x00000001_00000002_00000003_00000004; beat_cnt reads 2 before the flush and 0 after.
- 3 beats, lock high for 5 cycles with in_vld=1 and data 0xDEADBEEF -> in_rdy=0, beat_cnt stays 3, no out_ce; release lock -> 0xDEADBEEF accepted as beat 4 and out_ce fires one cycle later.
- Continuous in_vld for 10 cycles -> 2 words committed, out_ce pulses exactly 5 cycles apart, never high on adjacent cycles.
- rst driven low asynchronously mid-cycle after 2 beats -> all outputs 0 immediately, without waiting for a clock edge; after release, a fresh 4-beat word commits correctly with no stale beats.
